// File: rtl/ibus_responder.sv
// Instruction-memory responder for the fetch-stage ibus: fixed-latency word reads
// from an on-chip preloadable memory, with squash of abandoned or redirected fetches.
module ibus_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE      = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [31:0] load_data,
    output logic        fault,
    output logic [31:0] served,
    output logic [1:0]  state_dbg
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    // state_dbg encoding: 0 = IDLE, 1 = WAIT, 2 = RESP
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] req_addr;
    logic [3:0]  cnt;
    logic [31:0] rdata;
    logic        rfault;

    logic [31:0] mem [MEM_WORDS];

    // Unsigned 64-bit compare first, so addresses below BASE never wrap into range.
    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    logic        match;
    logic        accept;
    logic [63:0] cap_addr;
    logic        cap_bad;
    logic [31:0] cap_word;

    // Handshake: addr_ok marks the cycle a request is taken; data_ok is high for one
    // cycle only while the fetch stage still presents exactly req_addr with valid.
    always_comb begin
        match    = ireq_valid && (ireq_addr == req_addr);
        accept   = ireq_valid && ((state == IDLE) || !match);
        cap_addr = accept ? ireq_addr : req_addr;
        cap_bad  = (cap_addr[1:0] != 2'b00) || !in_range(cap_addr);
        cap_word = cap_bad ? 32'h0 : mem[word_idx(cap_addr)];
    end

    assign iresp_addr_ok = !reset && accept;
    assign iresp_data_ok = (state == RESP) && match;
    assign iresp_data    = (state == RESP) ? rdata : 32'h0;
    assign fault         = rfault && iresp_data_ok;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (load_en && in_range(load_addr)) begin
            mem[word_idx(load_addr)] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= 64'h0;
            cnt      <= 4'h0;
            rdata    <= 32'h0;
            rfault   <= 1'b0;
            served   <= 32'h0;
        end else if (accept) begin
            // Fresh request from IDLE, or a redirect that abandons the current one.
            req_addr <= ireq_addr;
            if (LATENCY == 1) begin
                rdata  <= cap_word;
                rfault <= cap_bad;
                state  <= RESP;
            end else begin
                cnt   <= CNT_INIT;
                state <= WAIT;
            end
        end else if ((state != IDLE) && !match) begin
            state <= IDLE;
        end else begin
            case (state)
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rdata  <= cap_word;
                        rfault <= cap_bad;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    served <= served + 32'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Instruction-bus responder that serves fetch-stage `ibus_req_t` requests from an on-chip 32-bit word memory with a fixed, parameterised latency. It stands on the memory side of the ibus, opposite the fetch stage, and serves as the instruction memory in simulation and bring-up builds. It squashes any in-flight request that the fetch stage abandons or redirects, so it never returns data for a stale PC.

## Interface
- `MEM_WORDS`, 4096: number of 32-bit instruction words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `data_ok`; legal range 1..15.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ireq`  in  `ibus_req_t`  fetch request (`valid`, `addr` u64).
- `iresp`  out  `ibus_resp_t`  response (`addr_ok`, `data_ok`, `data` u32).
- `load_en`  in  1  memory preload write strobe.
- `load_addr`  in  u64  preload byte address; word-aligned.
- `load_data`  in  u32  preload word.
- `fault`  out  1  current response is misaligned or out of range.
- `served`  out  u32  count of completed (`data_ok`) responses.

## Operation
- Word index `idx = (addr - BASE) >> 2`. Address is in range when `BASE <= addr < BASE + 4*MEM_WORDS`. Subtraction is 64-bit and no wrap is permitted: an address below BASE is out of range.
- State machine: IDLE, WAIT, RESP. Registers: `req_addr` u64, `cnt` 4-bit, `rdata` u32, `rfault` 1.
- IDLE: `addr_ok = ireq.valid` (combinational). On a clock edge with `ireq.valid`, latch `req_addr`.
  - If LATENCY==1, capture `rdata`/`rfault` and go to RESP.
  - Otherwise go to WAIT with `cnt = LATENCY-1`.
- WAIT: `cnt` decrements each edge.
  - On the edge where `cnt==1`, capture `rdata = mem[idx(req_addr)]` and `rfault`, then go to RESP.
- RESP: `data_ok = ireq.valid && ireq.addr == req_addr`, `data = rdata`, `fault = rfault && data_ok`.
  - On the edge, go to IDLE if `data_ok`, and increment `served` (wraps modulo 2^32).
- Squash: in WAIT or RESP, if `!ireq.valid` or `ireq.addr != req_addr`, `data_ok` stays 0.
  - On the next edge, abandon the request. If `ireq.valid`, accept the new address as in IDLE (restart latency, `addr_ok=1` that cycle); otherwise go to IDLE.
- Fault data: a misaligned (`addr[1:0] != 0`) or out-of-range request returns `data = 32'h0`, `fault = 1`, and still completes with `data_ok`.
- Preload: on an edge with `load_en` and an in-range `load_addr`, write `mem[idx] = load_data`. An out-of-range load is ignored. A load is visible to any capture on a later edge. A capture on the same edge as the load reads the old word.
- `addr_ok` is 0 in WAIT and RESP, except on a squash-and-reaccept cycle.
- The fetch stage holds `valid` and `addr` until `data_ok` or a redirect. The responder requires nothing else of it.

## Timing
- Reset: asynchronous, takes effect immediately. Reset values: state IDLE, `iresp` all zero, `fault` 0, `served` 0, `cnt` 0, `rdata` 0, `req_addr` 0. Memory contents are not reset.
- Reset asserted mid-request drops the request with no `data_ok`. The first request after reset release is accepted on the first edge with `valid`.
- Request accepted at edge E. `data_ok` is high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after the acceptance cycle.
- Back-to-back throughput: one response per LATENCY+1 cycles. The IDLE cycle after `data_ok` accepts the next request.
- `data_ok` is asserted for exactly one cycle per completed request and never for an address other than `req_addr`.
- `served` increments on the same edge that leaves RESP with `data_ok`.

## Test plan
- Preload `mem[0]=32'h0000_0013`, then request addr 64'h8000_0000 with LATENCY=2 -> `addr_ok` in cycle 0, `data_ok=1` with `data=32'h0000_0013` in cycle 2, `served=1`.
- Sequential fetch of 64'h8000_0000/4/8, with valid held and addr advanced on each `data_ok` -> three responses at cycles 2, 5, 8 with the correct words, `served=3`.
- Redirect: request 64'h8000_0000, change addr to 64'h8000_0100 in cycle 1 -> no `data_ok` for 0x..000. New request accepted in cycle 1. `data_ok` with `mem[64]` in cycle 3.
- Fault: request 64'h8000_0002, then 64'h7FFF_FFFC -> each completes with `data=0` and `fault=1` only in its `data_ok` cycle.
- Valid dropped in WAIT -> state returns to IDLE, no `data_ok`, `served` unchanged. Reset pulsed mid-WAIT -> all outputs 0 immediately.
- Load/capture race: write `mem[1]=32'hDEAD_BEEF` on the capture edge of a request to 0x8000_0004 -> the old word is returned. The next request returns 32'hDEAD_BEEF.
